// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word and RAM-state definitions plus the responder's
// FSM state and instruction-buffer entry.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned TAG_W  = 30;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    DACC,
    IACC,
    HALTED
  } mresp_state_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    word_t            data;
  } ibuf_entry_t;

  // Word address (byte address without the two offset bits).
  function automatic logic [TAG_W-1:0] word_tag(input word_t addr);
    return addr[WORD_W-1:2];
  endfunction

endpackage

// File: rtl/datapath_cache_if.sv
// Request/response bundle between the pipelined datapath and the memory side.
interface datapath_cache_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  halt;
  logic  ihit;
  logic  dhit;
  word_t imemload;
  word_t dmemload;

  modport cache (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
    output ihit, dhit, imemload, dmemload
  );

  modport dp (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
    input  ihit, dhit, imemload, dmemload
  );

endinterface

// File: rtl/ifetch_buf.sv
// One-entry instruction fetch buffer: combinational lookup, fill on a completed
// fetch, invalidate when a data write hits the buffered word.
module ifetch_buf
  import cpu_types_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             hit_c_o,
  output word_t            data_o,
  input  logic             fill_i,
  input  logic [TAG_W-1:0] fill_tag_i,
  input  word_t            fill_data_i,
  input  logic             inval_i,
  input  logic [TAG_W-1:0] inval_tag_i
);

  ibuf_entry_t entry_q;
  ibuf_entry_t entry_d;

  always_comb begin
    entry_d = entry_q;
    if (fill_i) begin
      entry_d.valid = 1'b1;
      entry_d.tag   = fill_tag_i;
      entry_d.data  = fill_data_i;
    end else if (inval_i && (entry_q.tag == inval_tag_i)) begin
      entry_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign hit_c_o = entry_q.valid && (entry_q.tag == lookup_tag_i);
  assign data_o  = entry_q.data;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates data over instruction requests onto a
// single-port RAM, with a fetch buffer, halt/flush handshake and watchdog.
module mem_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic            CLK,
  input  logic            nRST,
  datapath_cache_if.cache dpif,
  output word_t           ramaddr,
  output word_t           ramstore,
  output logic            ramREN,
  output logic            ramWEN,
  input  word_t           ramload,
  input  ramstate_t       ramstate,
  output logic            flushed,
  output logic            err
);

  localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  mresp_state_t     state_q;
  word_t            addr_q;
  word_t            data_q;
  logic             wr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_q;

  logic  acc_c, done_c, dreq_c, timeout_c;
  logic  ibuf_hit_c, idle_ihit_c, iacc_ihit_c, dacc_dhit_c;
  logic  fill_c, inval_c;
  word_t ibuf_data;

  assign acc_c     = (state_q == DACC) || (state_q == IACC);
  assign done_c    = acc_c && (ramstate == ACCESS);
  assign dreq_c    = dpif.dmemREN | dpif.dmemWEN;
  assign cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout_c = acc_c && !done_c && (cnt_d == CNT_MAX);

  // Hits only fire while the requester still asks for the same address.
  assign idle_ihit_c = (state_q == IDLE) && !dpif.halt && !dreq_c
                       && dpif.imemREN && ibuf_hit_c;
  assign iacc_ihit_c = (state_q == IACC) && done_c && dpif.imemREN
                       && (dpif.imemaddr == addr_q);
  assign dacc_dhit_c = (state_q == DACC) && done_c && dreq_c
                       && (dpif.dmemaddr == addr_q);

  assign fill_c  = (state_q == IACC) && done_c;
  assign inval_c = (state_q == DACC) && done_c && wr_q;

  ifetch_buf u_ibuf (
    .clk_i        (CLK),
    .rst_n_i      (nRST),
    .lookup_tag_i (word_tag(dpif.imemaddr)),
    .hit_c_o      (ibuf_hit_c),
    .data_o       (ibuf_data),
    .fill_i       (fill_c),
    .fill_tag_i   (word_tag(addr_q)),
    .fill_data_i  (ramload),
    .inval_i      (inval_c),
    .inval_tag_i  (word_tag(addr_q))
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dpif.halt) begin
            state_q <= HALTED;
          end else if (dreq_c) begin
            addr_q  <= dpif.dmemaddr;
            data_q  <= dpif.dmemstore;
            wr_q    <= dpif.dmemWEN;
            state_q <= DACC;
          end else if (dpif.imemREN && !ibuf_hit_c) begin
            addr_q  <= dpif.imemaddr;
            data_q  <= '0;
            wr_q    <= 1'b0;
            state_q <= IACC;
          end
        end
        DACC, IACC: begin
          if (done_c) begin
            state_q <= dpif.halt ? HALTED : IDLE;
            cnt_q   <= '0;
          end else if (timeout_c) begin
            err_q   <= 1'b1;
            cnt_q   <= cnt_d;
            state_q <= HALTED;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // RAM side is driven purely from the latched request.
  assign ramaddr  = acc_c ? {addr_q[31:2], 2'b00} : '0;
  assign ramstore = acc_c ? data_q : '0;
  assign ramREN   = (state_q == IACC) || ((state_q == DACC) && !wr_q);
  assign ramWEN   = (state_q == DACC) && wr_q;
  assign flushed  = (state_q == HALTED);
  assign err      = err_q;

  assign dpif.ihit     = idle_ihit_c | iacc_ihit_c;
  assign dpif.dhit     = dacc_dhit_c;
  assign dpif.imemload = idle_ihit_c ? ibuf_data : (iacc_ihit_c ? ramload : '0);
  assign dpif.dmemload = dacc_dhit_c ? ramload : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: latency-programmable RAM model, expected
// hits queued by the stimulus and checked by an independent monitor.
module tb_mem_responder;
  import cpu_types_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic      CLK;
  logic      nRST;
  word_t     ramaddr, ramstore, ramload;
  logic      ramREN, ramWEN, flushed, err;
  ramstate_t ramstate;

  datapath_cache_if dpif ();

  mem_responder #(.TIMEOUT_CYCLES(64)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .dpif     (dpif),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramload  (ramload),
    .ramstate (ramstate),
    .flushed  (flushed),
    .err      (err)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   lat_cfg = 3;
  int   acc_cyc = 0;
  logic init_mem = 1'b1;
  logic [31:0] mem [0:255];
  exp_t iq[$];
  exp_t dq[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // RAM model: lat_cfg BUSY cycles, then one ACCESS cycle.
  always @(posedge CLK) begin
    if (init_mem) begin
      foreach (mem[i]) mem[i] <= '0;
      mem[8'h10] <= 32'h8C22_0004;
      mem[8'h11] <= 32'h3333_4444;
      mem[8'h12] <= 32'h5555_6666;
      mem[8'h20] <= 32'h7777_8888;
      mem[8'h40] <= 32'h1111_2222;
    end else if (ramWEN && (ramstate == ACCESS)) begin
      mem[ramaddr[9:2]] <= ramstore;
    end
    if ((ramREN || ramWEN) && (ramstate != ACCESS)) acc_cyc <= acc_cyc + 1;
    else acc_cyc <= 0;
  end

  always_comb begin
    ramstate = FREE;
    if (ramREN || ramWEN) ramstate = (acc_cyc >= lat_cfg) ? ACCESS : BUSY;
  end

  assign ramload = mem[ramaddr[9:2]];

  // Monitor: every hit must match the oldest queued expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (dpif.ihit && dpif.dhit) begin
      n_tests++;
      n_fail++;
      $display("FAIL both_hits: ihit and dhit together at cyc %0d", cyc);
    end
    if (dpif.ihit) begin
      n_tests++;
      if (iq.size() == 0) begin
        n_fail++;
        $display("FAIL ihit_unexpected: got data=%h at cyc %0d, none expected", dpif.imemload, cyc);
      end else begin
        e = iq.pop_front();
        if (dpif.imemload !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL ihit: got data=%h cyc=%0d expected data=%h cyc=%0d", dpif.imemload, cyc, e.data, e.cyc);
        end
      end
    end
    if (dpif.dhit) begin
      n_tests++;
      if (dq.size() == 0) begin
        n_fail++;
        $display("FAIL dhit_unexpected: got data=%h at cyc %0d, none expected", dpif.dmemload, cyc);
      end else begin
        e = dq.pop_front();
        if (dpif.dmemload !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL dhit: got data=%h cyc=%0d expected data=%h cyc=%0d", dpif.dmemload, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_i(input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    iq.push_back(e);
  endtask

  task automatic push_d(input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    dq.push_back(e);
  endtask

  initial begin
    int c;
    nRST = 1'b0;
    dpif.imemREN = 1'b0; dpif.imemaddr = '0;
    dpif.dmemREN = 1'b0; dpif.dmemWEN  = 1'b0;
    dpif.dmemaddr = '0;  dpif.dmemstore = '0;
    dpif.halt = 1'b0;
    step();
    step();
    init_mem = 1'b0;
    @(negedge CLK);
    chk("rst_ihit", 32'(dpif.ihit), 32'd0);
    chk("rst_dhit", 32'(dpif.dhit), 32'd0);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_flushed", 32'(flushed), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_imemload", dpif.imemload, 32'd0);
    chk("rst_dmemload", dpif.dmemload, 32'd0);
    step();
    nRST = 1'b1;

    // Instruction miss, then the same fetch answered from the buffer.
    c = cyc;
    dpif.imemREN = 1'b1; dpif.imemaddr = 32'h40;
    push_i(32'h8C22_0004, c + 4);
    step();
    @(negedge CLK);
    chk("imiss_ramREN", 32'(ramREN), 32'd1);
    chk("imiss_ramaddr", ramaddr, 32'h40);
    repeat (4) step();
    push_i(32'h8C22_0004, c + 5);
    @(negedge CLK);
    chk("ibuf_hit_ramREN", 32'(ramREN), 32'd0);
    step();
    dpif.imemREN = 1'b0;

    // Data request wins over a simultaneous fetch.
    c = cyc;
    dpif.dmemREN = 1'b1; dpif.dmemaddr = 32'h100;
    dpif.imemREN = 1'b1; dpif.imemaddr = 32'h44;
    push_d(32'h1111_2222, c + 4);
    push_i(32'h3333_4444, c + 9);
    step();
    @(negedge CLK);
    chk("prio_ramaddr_d", ramaddr, 32'h100);
    repeat (4) step();
    dpif.dmemREN = 1'b0;
    step();
    @(negedge CLK);
    chk("prio_ramaddr_i", ramaddr, 32'h44);
    repeat (4) step();
    dpif.imemREN = 1'b0;

    // Refill 0x40, then a store to 0x40 must invalidate it.
    c = cyc;
    dpif.imemREN = 1'b1; dpif.imemaddr = 32'h40;
    push_i(32'h8C22_0004, c + 4);
    repeat (5) step();
    c = cyc;
    dpif.imemREN = 1'b0;
    dpif.dmemWEN = 1'b1; dpif.dmemaddr = 32'h40; dpif.dmemstore = 32'hDEAD_BEEF;
    push_d(32'h8C22_0004, c + 4);
    step();
    @(negedge CLK);
    chk("sw_ramWEN", 32'(ramWEN), 32'd1);
    chk("sw_ramREN", 32'(ramREN), 32'd0);
    chk("sw_ramstore", ramstore, 32'hDEAD_BEEF);
    repeat (4) step();
    c = cyc;
    dpif.dmemWEN = 1'b0;
    dpif.imemREN = 1'b1; dpif.imemaddr = 32'h40;
    push_i(32'hDEAD_BEEF, c + 4);
    step();
    @(negedge CLK);
    chk("inval_refetch_ramREN", 32'(ramREN), 32'd1);
    repeat (4) step();
    dpif.imemREN = 1'b0;

    // Fetch address moves while BUSY: silent completion, 0x48 still buffered.
    c = cyc;
    dpif.imemREN = 1'b1; dpif.imemaddr = 32'h48;
    step();
    step();
    dpif.imemaddr = 32'h80;
    repeat (3) step();
    dpif.imemaddr = 32'h48;
    push_i(32'h5555_6666, c + 5);
    step();
    dpif.imemaddr = 32'h80;
    push_i(32'h7777_8888, c + 10);
    step();
    @(negedge CLK);
    chk("moved_ramaddr", ramaddr, 32'h80);
    repeat (4) step();
    dpif.imemREN = 1'b0;

    // Halt during a write: write completes, then HALTED ignores requests.
    c = cyc;
    dpif.dmemWEN = 1'b1; dpif.dmemaddr = 32'h200; dpif.dmemstore = 32'hCAFE_F00D;
    push_d(32'h0, c + 4);
    step();
    dpif.halt = 1'b1;
    repeat (4) step();
    dpif.dmemWEN = 1'b0;
    dpif.dmemREN = 1'b1; dpif.dmemaddr = 32'h100;
    dpif.imemREN = 1'b1; dpif.imemaddr = 32'h40;
    @(negedge CLK);
    chk("halt_flushed", 32'(flushed), 32'd1);
    chk("halt_ramREN", 32'(ramREN), 32'd0);
    chk("halt_ramWEN", 32'(ramWEN), 32'd0);
    repeat (3) step();
    @(negedge CLK);
    chk("halt_ramREN_later", 32'(ramREN), 32'd0);
    chk("halt_write_landed", mem[8'h80], 32'hCAFE_F00D);
    dpif.dmemREN = 1'b0; dpif.imemREN = 1'b0; dpif.halt = 1'b0;

    // Watchdog: RAM never answers.
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    lat_cfg = 1000;
    c = cyc;
    dpif.dmemREN = 1'b1; dpif.dmemaddr = 32'h100;
    @(negedge CLK);
    chk("to_rst_flushed", 32'(flushed), 32'd0);
    repeat (64) step();
    @(negedge CLK);
    chk("to_err_before", 32'(err), 32'd0);
    chk("to_ramREN_before", 32'(ramREN), 32'd1);
    step();
    @(negedge CLK);
    chk("to_err", 32'(err), 32'd1);
    chk("to_ramREN", 32'(ramREN), 32'd0);
    chk("to_flushed", 32'(flushed), 32'd1);
    dpif.dmemREN = 1'b0;
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    @(negedge CLK);
    chk("to_clr_err", 32'(err), 32'd0);
    chk("to_clr_flushed", 32'(flushed), 32'd0);

    // Back in IDLE: minimum-latency fetch and load.
    lat_cfg = 0;
    step();
    c = cyc;
    dpif.imemREN = 1'b1; dpif.imemaddr = 32'h44;
    push_i(32'h3333_4444, c + 1);
    step();
    step();
    dpif.imemREN = 1'b0;
    dpif.dmemREN = 1'b1; dpif.dmemaddr = 32'h100;
    push_d(32'h1111_2222, c + 3);
    step();
    step();
    dpif.dmemREN = 1'b0;
    repeat (3) step();

    chk("iq_drained", 32'(iq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for datapath_cache_if. Serves the pipelined datapath's instruction and data requests over a single-port RAM with variable latency.
- Data requests take priority over instruction fetches.
- A one-entry instruction fetch buffer answers repeated fetches of the same address, for example during pipeline stalls.
- Owns the halt and flush handshake and a watchdog timeout on RAM accesses.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles a single RAM access may stay outstanding before err is raised.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the watchdog counter. Derived; do not override.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- nRST  in  1  reset, synchronous, active-low.
- dpif  modport  -  datapath_cache_if cache-side modport.
  - Inputs: imemREN, imemaddr[31:0], dmemREN, dmemWEN, dmemaddr[31:0], dmemstore[31:0], halt.
  - Outputs: ihit, dhit, imemload[31:0], dmemload[31:0].
- ramaddr  out  32  word-aligned RAM address.
- ramstore  out  32  RAM write data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramload  in  32  RAM read data, valid when ramstate==ACCESS.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- flushed  out  1  high once halted and no access is outstanding.
- err  out  1  sticky, set on watchdog timeout.

Behaviour:
- States: IDLE, DACC, IACC, HALTED.
- Reset (nRST==0 at a clock edge):
  - state=IDLE; ibuf_valid=0; counter=0; err=0; latched address, data and write flag all 0.
  - Outputs after reset: ihit=dhit=0, ramREN=ramWEN=0, ramaddr=0, ramstore=0, flushed=0, imemload=dmemload=0.
  - Reset asserted mid-access abandons the access; no hit is produced.
- IDLE transitions, evaluated in priority order:
  - halt=1: go to HALTED.
  - dmemREN|dmemWEN: latch {dmemaddr, dmemstore, wr=dmemWEN}, go to DACC.
  - imemREN with buffer hit (ibuf_valid and ibuf_addr==imemaddr[31:2]): ihit=1 combinationally this cycle, imemload=ibuf_data, stay in IDLE. No RAM access.
  - imemREN with buffer miss: latch imemaddr, go to IACC.
- DACC and IACC drive the RAM from latched values only:
  - ramaddr={addr[31:2],2'b00}.
  - ramREN = ~wr in DACC, 1 in IACC.
  - ramWEN = wr in DACC, 0 in IACC.
  - ramstore = latched data.
- Completion: a cycle with ramstate==ACCESS while in DACC or IACC. Then return to IDLE at the next edge (or HALTED if halt=1) and clear the counter.
- Hits are combinational in the completion cycle:
  - DACC: dhit=1 and dmemload=ramload, but only if dmemREN|dmemWEN is still asserted and dmemaddr equals the latched address. Otherwise the access completes silently (writes are never aborted).
  - IACC: ihit=1 and imemload=ramload under the equivalent condition on imemREN/imemaddr. The buffer is filled {latched addr, ramload}, valid=1, regardless of whether ihit fires.
- At most one hit per cycle. ihit and dhit are never high together.
- BUSY and ERROR: hold state and keep driving the RAM. ERROR is retried implicitly.
- Watchdog:
  - The counter increments each cycle in DACC or IACC and saturates.
  - When the counter reaches TIMEOUT_CYCLES without completion: set err, deassert RAM enables, go to HALTED.
- Buffer coherence:
  - A data write completing to word address == ibuf_addr clears ibuf_valid at that edge.
  - An instruction fill and a write cannot collide, since only one access is outstanding.
- halt asserted during DACC or IACC: the access completes first, then the block enters HALTED.
- HALTED:
  - RAM enables 0, ihit=dhit=0, flushed=1.
  - All requests are ignored.
  - The only exit is reset.
- Back-to-back requests: each access spends at least one IDLE cycle between completions. Minimum data latency is 2 cycles (IDLE, then DACC with ACCESS).

Decomposition:
- cpu_types_pkg (existing) supplies word_t and ramstate_t.
- New entries in cpu_types_pkg:
  - mresp_state_t enum {IDLE, DACC, IACC, HALTED}.
  - Buffer entry struct {valid, tag[29:0], data word_t}.
- Natural sub-module: ifetch_buf. It holds the one-entry buffer with lookup, fill and invalidate ports. The FSM, watchdog and muxing stay in mem_responder.

Test Plan:
- Instruction miss then repeat: imemREN, imemaddr=0x40, RAM gives BUSY×3 then ACCESS with ramload=0x8C220004.
  - ihit in cycle 5 with imemload=0x8C220004.
  - Same fetch again: ihit in the same cycle, ramREN=0.
- Priority: dmemREN at 0x100 and imemREN at 0x44 both asserted in IDLE.
  - RAM sees 0x100 first, dhit.
  - Then IDLE, then fetch of 0x44, ihit.
- Write invalidates buffer: buffer holds 0x40, then sw to 0x40 with dmemstore=0xDEADBEEF.
  - dhit, ramWEN=1, ramstore=0xDEADBEEF.
  - Next fetch of 0x40 goes to RAM (miss).
- Request changes mid-fetch: imemaddr moves 0x48→0x80 during BUSY.
  - No ihit at completion; buffer holds 0x48; next fetch of 0x80 is issued.
- Halt during DACC: halt=1 while BUSY.
  - Write completes with dhit, then HALTED: flushed=1; later requests produce no RAM enables.
- Timeout: ramstate=BUSY forever, TIMEOUT_CYCLES=64.
  - err=1 after 64 cycles in DACC, ramREN=0, flushed=1.
  - nRST low for one edge clears err and returns to IDLE.
